// File: rtl/logic_sweep_checker.sv
// Exhaustive sweep engine: drives every input vector onto a combinational function and
// compares the sampled output against a truth table, reporting mismatch count and first failure.
module logic_sweep_checker #(
  parameter int unsigned             N_IN        = 4,
  parameter int unsigned             STEP_CYCLES = 1,
  parameter logic [(2**N_IN)-1:0]    TRUTH       = 16'hF830
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            vec_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [7:0]      HoldLast = 8'(STEP_CYCLES - 1);
  localparam logic [N_IN-1:0] VecLast  = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic            ffv_q, ffv_d;
  logic            sample, mismatch;

  assign sample   = (hold_q == HoldLast);
  assign mismatch = (dut_out != TRUTH[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    idx_d   = idx_q;
    ffv_d   = ffv_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          idx_d   = '0;
          ffv_d   = 1'b0;
        end
      end
      StDrive: begin
        // start is deliberately ignored here; a sweep always runs to completion
        if (!sample) begin
          hold_d = hold_q + 8'd1;
        end else begin
          hold_d = '0;
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!ffv_q) begin
              idx_d = vec_q;
              ffv_d = 1'b1;
            end
          end
          if (vec_q == VecLast) begin
            state_d = StDone;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      ffv_q   <= ffv_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = (state_q == StDrive);
  assign vec_valid        = busy;
  assign done             = (state_q == StDone);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_idx   = idx_q;
  assign first_fail_valid = ffv_q;

endmodule
